// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM with memory wait states, a memory timeout
// and illegal-opcode detection.
// Optional feature macro: MIPS_CTRL_BNE_EN adds the bne path (BNEEX state, branch_ne).
module mips_multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       branch_ne,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    localparam int unsigned CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_t;

    state_t          state_r, state_n;
    logic [CW-1:0]   cnt_r, cnt_n;
    logic            mem_wait;
    logic            tmo;

    assign state = state_r;

    // State register and memory wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Next-state, timeout and output decode
    always_comb begin
        state_n    = state_r;
        cnt_n      = '0;
        mem_wait   = 1'b0;
        tmo        = 1'b0;
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        illegal_op = 1'b0;
        mem_err    = 1'b0;

        case (state_r)
            S_FETCH: begin
                mem_req  = 1'b1;
                alusrcb  = 2'b01;
                irwrite  = mem_ready;
                pcwrite  = mem_ready;
                mem_wait = 1'b1;
                if (mem_ready) state_n = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_RTYPEEX;
                    OP_BEQ:       state_n = S_BEQEX;
                    OP_ADDI:      state_n = S_ADDIEX;
                    OP_J:         state_n = S_JEX;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_n = S_BNEEX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_n    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                mem_wait = 1'b1;
                if (mem_ready) state_n = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_n  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                mem_wait = 1'b1;
                if (mem_ready) state_n = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_n = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_n  = S_FETCH;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_n = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_n = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_n  = S_FETCH;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_n = S_FETCH;
            end
`ifdef MIPS_CTRL_BNE_EN
            S_BNEEX: begin
                alusrca   = 1'b1;
                aluop     = 2'b01;
                pcsrc     = 2'b01;
                branch_ne = 1'b1;
                state_n   = S_FETCH;
            end
`endif
            default: state_n = S_FETCH;
        endcase

        // A stalled access aborts on the last allowed wait cycle; mem_ready wins.
        if (MEM_TIMEOUT != 0 && mem_wait && !mem_ready) begin
            if (cnt_r == TMO_LAST) begin
                tmo = 1'b1;
            end else begin
                cnt_n = cnt_r + CW'(1);
            end
        end

        if (tmo) begin
            mem_err  = 1'b1;
            mem_req  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            state_n  = S_FETCH;
        end

        // Hold strobes low while reset is asserted; selects keep FETCH decode.
        if (reset) begin
            mem_req    = 1'b0;
            iord       = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            pcwrite    = 1'b0;
            branch     = 1'b0;
            branch_ne  = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            pcsrc      = 2'b00;
            illegal_op = 1'b0;
            mem_err    = 1'b0;
            cnt_n      = '0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control (MEM_TIMEOUT = 4).
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b0;
    logic       mem_req, iord, memwrite, irwrite, pcwrite, branch, branch_ne;
    logic       regdst, memtoreg, regwrite, alusrca, illegal_op, mem_err;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state;

    int checks = 0;
    int passed = 0;

    mips_multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .pcwrite(pcwrite), .branch(branch), .branch_ne(branch_ne),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
        .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    // Field order: mem_req iord memwrite irwrite pcwrite branch branch_ne
    //              regdst memtoreg regwrite alusrca | alusrcb | aluop | pcsrc | illegal_op mem_err
    logic [18:0] act;
    assign act = {mem_req, iord, memwrite, irwrite, pcwrite, branch, branch_ne,
                  regdst, memtoreg, regwrite, alusrca, alusrcb, aluop, pcsrc,
                  illegal_op, mem_err};

    localparam logic [18:0] O_RESET    = 19'b00000000000_01_00_00_0_0;
    localparam logic [18:0] O_FR       = 19'b10011000000_01_00_00_0_0;
    localparam logic [18:0] O_FW       = 19'b10000000000_01_00_00_0_0;
    localparam logic [18:0] O_FTMO     = 19'b00000000000_01_00_00_0_1;
    localparam logic [18:0] O_DEC      = 19'b00000000000_11_00_00_0_0;
    localparam logic [18:0] O_DEC_ILL  = 19'b00000000000_11_00_00_1_0;
    localparam logic [18:0] O_MEMADR   = 19'b00000000001_10_00_00_0_0;
    localparam logic [18:0] O_MEMRD    = 19'b11000000000_00_00_00_0_0;
    localparam logic [18:0] O_MEMTMO   = 19'b01000000000_00_00_00_0_1;
    localparam logic [18:0] O_MEMWB    = 19'b00000000110_00_00_00_0_0;
    localparam logic [18:0] O_MEMWR    = 19'b11100000000_00_00_00_0_0;
    localparam logic [18:0] O_RTEX     = 19'b00000000001_00_10_00_0_0;
    localparam logic [18:0] O_RTWB     = 19'b00000001010_00_00_00_0_0;
    localparam logic [18:0] O_BEQ      = 19'b00000100001_00_01_01_0_0;
    localparam logic [18:0] O_ADDIWB   = 19'b00000000010_00_00_00_0_0;
    localparam logic [18:0] O_JEX      = 19'b00001000000_00_00_10_0_0;
    localparam logic [18:0] O_BNE      = 19'b00000010001_00_01_01_0_0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] BNE = 6'b000101, BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  opc;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] outs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [5:0] o, input logic rdy,
                       input logic [3:0] st, input logic [18:0] outs);
        vec_t v;
        v.rst = r; v.opc = o; v.rdy = rdy; v.st = st; v.outs = outs;
        vecs.push_back(v);
    endtask

    task automatic compare(input string name, input int id,
                           input logic [18:0] a, input logic [18:0] e);
        checks++;
        if (a !== e)
            $display("FAIL %s #%0d: got %b, required %b", name, id, a, e);
        else
            passed++;
    endtask

    // Apply one cycle of inputs after the edge, compare mid-cycle.
    task automatic step(input int id, input logic r, input logic [5:0] o, input logic rdy,
                        input logic [3:0] st, input logic [18:0] outs);
        @(posedge clk);
        #1;
        reset = r; op = o; mem_ready = rdy;
        #3;
        compare("state", id, {15'd0, state}, {15'd0, st});
        compare("outs", id, act, outs);
    endtask

    initial begin
        // reset holds everything idle, even with mem_ready high
        add(1, RT, 0, 0, O_RESET);
        add(1, RT, 1, 0, O_RESET);
        // lw, no waits: 0,1,2,3,4
        add(0, LW, 1, 0, O_FR);
        add(0, LW, 1, 1, O_DEC);
        add(0, LW, 1, 2, O_MEMADR);
        add(0, LW, 1, 3, O_MEMRD);
        add(0, LW, 1, 4, O_MEMWB);
        // R-type
        add(0, RT, 1, 0, O_FR);
        add(0, RT, 1, 1, O_DEC);
        add(0, RT, 1, 6, O_RTEX);
        add(0, RT, 1, 7, O_RTWB);
        // sw with three wait states
        add(0, SW, 1, 0, O_FR);
        add(0, SW, 1, 1, O_DEC);
        add(0, SW, 1, 2, O_MEMADR);
        add(0, SW, 0, 5, O_MEMWR);
        add(0, SW, 0, 5, O_MEMWR);
        add(0, SW, 0, 5, O_MEMWR);
        add(0, SW, 1, 5, O_MEMWR);
        // beq
        add(0, BEQ, 1, 0, O_FR);
        add(0, BEQ, 1, 1, O_DEC);
        add(0, BEQ, 1, 8, O_BEQ);
        // addi
        add(0, ADDI, 1, 0, O_FR);
        add(0, ADDI, 1, 1, O_DEC);
        add(0, ADDI, 1, 9, O_MEMADR);
        add(0, ADDI, 1, 10, O_ADDIWB);
        // j after one fetch wait state
        add(0, JMP, 0, 0, O_FW);
        add(0, JMP, 1, 0, O_FR);
        add(0, JMP, 1, 1, O_DEC);
        add(0, JMP, 1, 11, O_JEX);
        // unsupported opcode
        add(0, BAD, 1, 0, O_FR);
        add(0, BAD, 1, 1, O_DEC_ILL);
        // bne
        add(0, BNE, 1, 0, O_FR);
`ifdef MIPS_CTRL_BNE_EN
        add(0, BNE, 1, 1, O_DEC);
        add(0, BNE, 1, 12, O_BNE);
`else
        add(0, BNE, 1, 1, O_DEC_ILL);
`endif

        foreach (vecs[i])
            step(i, vecs[i].rst, vecs[i].opc, vecs[i].rdy, vecs[i].st, vecs[i].outs);

        // lw stalled in MEMRD: mem_err on the 4th wait cycle, back to FETCH
        step(100, 0, LW, 1, 0, O_FR);
        step(101, 0, LW, 1, 1, O_DEC);
        step(102, 0, LW, 1, 2, O_MEMADR);
        step(103, 0, LW, 0, 3, O_MEMRD);
        step(104, 0, LW, 0, 3, O_MEMRD);
        step(105, 0, LW, 0, 3, O_MEMRD);
        step(106, 0, LW, 0, 3, O_MEMTMO);
        // fetch stall times out and restarts the fetch with a cleared count
        step(107, 0, LW, 0, 0, O_FW);
        step(108, 0, LW, 0, 0, O_FW);
        step(109, 0, LW, 0, 0, O_FW);
        step(110, 0, LW, 0, 0, O_FTMO);
        step(111, 0, LW, 0, 0, O_FW);
        step(112, 0, LW, 0, 0, O_FW);
        step(113, 0, LW, 0, 0, O_FW);
        // mem_ready on the would-be timeout cycle wins
        step(114, 0, SW, 1, 0, O_FR);
        step(115, 0, SW, 1, 1, O_DEC);
        step(116, 0, SW, 1, 2, O_MEMADR);
        step(117, 0, SW, 0, 5, O_MEMWR);
        // asynchronous reset in the middle of MEMWR
        #1;
        reset = 1'b1;
        #1;
        compare("async_state", 118, {15'd0, state}, 19'd0);
        compare("async_outs", 118, act, O_RESET);
        step(119, 1, SW, 1, 0, O_RESET);
        step(120, 0, SW, 1, 0, O_FR);
        step(121, 0, SW, 1, 1, O_DEC);
        step(122, 0, SW, 1, 2, O_MEMADR);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
